alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Sequencer around the 8-bit ALU, which is combinational (AND/XOR/ADD/LSHIFT, with zero and carry outputs).
//  - Accepts one instruction per valid/ready handshake.
//  - Reads operands from a small internal register file and drives the ALU operand/select inputs.
//  - Writes the ALU result back to the register file and holds carry/zero in flag registers.
//  - Sits directly upstream (feeds ALU inputs) and downstream (consumes ALU outputs) of the ALU.
// PARAMETERS
//  REG_AW     2      register index width; NUM_REGS = 2**REG_AW
//  RESET_VAL  8'h00  reset value of every register-file entry
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst          in   1       asynchronous reset, active-high
//  instValid    in   1       upstream instruction valid
//  instReady    out  1       block can accept an instruction (IDLE only)
//  instOp       in   2       ALU op: 00 AND, 01 XOR, 10 ADD, 11 LSHIFT(A)
//  instDst      in   REG_AW  destination register index
//  instSrcA     in   REG_AW  operand A register index
//  instSrcB     in   REG_AW  operand B register index (ignored if instUseImm)
//  instUseImm   in   1       1: operand B = instImm
//  instImm      in   8       immediate operand
//  aluA         out  8       to ALU operand A
//  aluB         out  8       to ALU operand B
//  aluSel       out  2       to ALU op select
//  aluResult    in   8       from ALU result
//  aluCout      in   1       from ALU carry out
//  aluZero      in   1       from ALU zero flag
//  doneValid    out  1       one-cycle pulse: instruction retired
//  doneData     out  8       result written by the retired instruction
//  carryFlag    out  1       registered carry of last retired instruction
//  zeroFlagReg  out  1       registered zero of last retired instruction
//  rdAddr       in   REG_AW  debug/read port index
//  rdData       out  8       combinational read of reg[rdAddr]
// BEHAVIOUR
//  Reset values
//   - FSM = IDLE; all registers = RESET_VAL.
//   - aluA, aluB, aluSel, doneData, doneValid, carryFlag, zeroFlagReg = 0.
//  FSM states: IDLE -> EXEC -> WB -> IDLE. Each state lasts exactly 1 cycle except IDLE.
//  IDLE
//   - instReady = 1.
//   - On edge with instValid & instReady: aluA <= reg[instSrcA]; aluB <= instUseImm ? instImm : reg[instSrcB].
//   - On the same edge: aluSel <= instOp; dst latched; go EXEC.
//  EXEC
//   - instReady = 0. The ALU settles on the registered operands.
//   - At the edge, aluResult/aluCout/aluZero are captured into internal result regs exactly as presented. No recomputation, no masking by op.
//   - Go WB.
//  WB
//   - instReady = 0.
//   - At the edge: reg[dst] <= captured result; doneData <= result; carryFlag <= cout; zeroFlagReg <= zero; doneValid <= 1.
//   - Go IDLE.
//  doneValid is high for exactly the first IDLE cycle after WB, then 0.
//  Latency: handshake edge T -> reg/flags/doneData updated at edge T+2 -> doneValid high in cycle T+2..T+3.
//  Throughput: 1 instruction per 3 cycles. A new instruction may be accepted in the same cycle doneValid is high.
//   - Its operand read sees the just-written value, so there is no hazard and no bypass is needed.
//  aluA/aluB/aluSel hold their last values in IDLE and change only on a handshake edge.
//  Instruction fields are sampled only on the handshake edge. Changes while instReady = 0 are ignored.
//   - Upstream holds instValid until accepted.
//  Flags update on every retired instruction, including AND/XOR. No other event modifies flags.
//  dst == srcA/srcB is legal: operands are taken before writeback.
//  rdData is combinational from the register file and reflects a WB write from the edge that performs it.
//  rst asserted in any state:
//   - Immediately return to IDLE and reset all state per the reset values above.
//   - The in-flight instruction is discarded: no doneValid, no writeback after release.
// TESTING
//  1. Reset, then release -> instReady=1, doneValid=0, carryFlag=0, zeroFlagReg=0, rdData=0x00 for all rdAddr.
//  2. ADD r1=r0+imm 0x05 (op10, dst1, srcA0, useImm) -> aluA=0x00, aluB=0x05, aluSel=10 in EXEC.
//     doneValid one cycle at T+2, doneData=0x05, rdData[1]=0x05, zeroFlagReg=0.
//  3. Back-to-back: issue r1=r1+r1 (op10, srcA1, srcB1) in the doneValid cycle of test 2 -> aluA=aluB=0x05.
//     doneData=0x0A, exactly two doneValid pulses, 3 cycles apart.
//  4. AND r2=r1&imm 0x00 -> doneData=0x00, rdData[2]=0x00, zeroFlagReg=1. A following XOR with a nonzero result clears zeroFlagReg.
//  5. Hold instValid=1 and toggle instImm during EXEC/WB -> instReady=0 both cycles.
//     Only the value present at the handshake reaches aluB. One doneValid per accepted instruction.
//  6. Assert rst during EXEC of ADD r3=r1+imm 0x10 -> after release no doneValid, rdData[3]=0x00, FSM IDLE, instReady=1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer wrapped around a combinational 8-bit ALU.
// Owns the register file and carry/zero flags; one instruction every 3 cycles.
module alu_issue_ctrl #(
  parameter int          REG_AW    = 2,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instValid,
  output logic              instReady,
  input  logic [1:0]        instOp,
  input  logic [REG_AW-1:0] instDst,
  input  logic [REG_AW-1:0] instSrcA,
  input  logic [REG_AW-1:0] instSrcB,
  input  logic              instUseImm,
  input  logic [7:0]        instImm,
  output logic [7:0]        aluA,
  output logic [7:0]        aluB,
  output logic [1:0]        aluSel,
  input  logic [7:0]        aluResult,
  input  logic              aluCout,
  input  logic              aluZero,
  output logic              doneValid,
  output logic [7:0]        doneData,
  output logic              carryFlag,
  output logic              zeroFlagReg,
  input  logic [REG_AW-1:0] rdAddr,
  output logic [7:0]        rdData
);

  // state | meaning
  // IDLE  | ready for an instruction; operands captured on handshake
  // EXEC  | ALU settles on registered operands; result/flags captured
  // WB    | captured result written to reg file, flags, doneData
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam int NUM_REGS = 2 ** REG_AW;

  state_t              state_q, state_d;
  logic [7:0]          regs_q [NUM_REGS];
  logic [7:0]          alu_a_q, alu_a_d;
  logic [7:0]          alu_b_q, alu_b_d;
  logic [1:0]          alu_sel_q, alu_sel_d;
  logic [REG_AW-1:0]   dst_q, dst_d;
  logic [7:0]          res_q, res_d;
  logic                cout_q, cout_d;
  logic                zero_q, zero_d;
  logic                done_valid_q, done_valid_d;
  logic [7:0]          done_data_q, done_data_d;
  logic                carry_q, carry_d;
  logic                zero_flag_q, zero_flag_d;
  logic                wr_en;
  logic                accept;

  assign accept = instValid && (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    dst_d        = dst_q;
    res_d        = res_q;
    cout_d       = cout_q;
    zero_d       = zero_q;
    done_valid_d = 1'b0;
    done_data_d  = done_data_q;
    carry_d      = carry_q;
    zero_flag_d  = zero_flag_q;
    wr_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_a_d   = regs_q[instSrcA];
          alu_b_d   = instUseImm ? instImm : regs_q[instSrcB];
          alu_sel_d = instOp;
          dst_d     = instDst;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // Taken exactly as the ALU presents them, whatever the op.
        res_d   = aluResult;
        cout_d  = aluCout;
        zero_d  = aluZero;
        state_d = WB;
      end
      WB: begin
        wr_en        = 1'b1;
        done_data_d  = res_q;
        carry_d      = cout_q;
        zero_flag_d  = zero_q;
        done_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      alu_sel_q    <= 2'b00;
      dst_q        <= '0;
      res_q        <= 8'h00;
      cout_q       <= 1'b0;
      zero_q       <= 1'b0;
      done_valid_q <= 1'b0;
      done_data_q  <= 8'h00;
      carry_q      <= 1'b0;
      zero_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      dst_q        <= dst_d;
      res_q        <= res_d;
      cout_q       <= cout_d;
      zero_q       <= zero_d;
      done_valid_q <= done_valid_d;
      done_data_q  <= done_data_d;
      carry_q      <= carry_d;
      zero_flag_q  <= zero_flag_d;
    end
  end

  // Operands are read in IDLE, so a write in WB is visible to the next issue without bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (wr_en) begin
      regs_q[dst_q] <= res_q;
    end
  end

  assign instReady   = (state_q == IDLE);
  assign aluA        = alu_a_q;
  assign aluB        = alu_b_q;
  assign aluSel      = alu_sel_q;
  assign doneValid   = done_valid_q;
  assign doneData    = done_data_q;
  assign carryFlag   = carry_q;
  assign zeroFlagReg = zero_flag_q;
  assign rdData      = regs_q[rdAddr];

endmodule
